operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Register-read/shift stage directly upstream of the execute stage. Takes a
//  decoded-stage instruction, reads up to three operands from the register
//  file, and applies the ARM operand-2 barrel shift or immediate rotate.
//  Registers op0/op1/op2/carry with pc/insn/cpsr for execute. Stalls itself
//  on a read-after-write interlock against the instruction currently in
//  execute.
// PARAMETERS
//  PC_AHEAD   8   byte offset added to pc when r15 is read as an operand
//  PC_AHEAD_RS 12  r15 read offset when the shift amount comes from a register
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  Nrst         in   1   reset, synchronous, active-high (1 = reset)
//  stall        in   1   execute cannot accept; hold output registers
//  flush        in   1   squash the stage (branch taken downstream)
//  inbubble     in   1   incoming slot empty
//  inpc         in   32  address of insn
//  insn         in   32  instruction word
//  cpsr         in   32  current flags (C is used by shifts and RRX)
//  rf_rna       out  4   read port A number (Rn, or Rm for MUL)
//  rf_rnb       out  4   read port B number (Rm, or Rs for MUL)
//  rf_rnc       out  4   read port C number (Rs shift amount / Rd store data / Rn acc)
//  rf_rda/b/c   in   32  read data, combinational from register file
//  exe_write_reg in  1   instruction in execute will write a register
//  exe_write_num in  4   that register number
//  outstall     out  1   to fetch/decode: hold insn this cycle
//  outbubble    out  1   execute slot empty
//  outpc, outinsn, outcpsr  out 32  registered copies for execute
//  op0, op1, op2 out 32  registered operands
//  carry        out  1   registered shifter carry-out
// BEHAVIOUR
//  - Reset: outbubble=1, carry=0, op0/op1/op2/outpc/outinsn/outcpsr=0. Reset
//    wins over stall and flush. Reset mid-stall drops the held instruction.
//  - Operand map:
//    ALU: op0=Rn, op1=shifted op2, op2=Rd value
//    MULT: op0=Rm, op1=Rs, op2=Rn (accumulator)
//    LDR/STR: op0=Rn, op1=imm12 or shifted Rm, op2=Rd (store data)
//    BRANCH: op0=sext(imm24)<<2
//    Other classes: operands don't-care, carry=cpsr C
//  - r15 source reads return inpc+PC_AHEAD, or inpc+PC_AHEAD_RS for
//    register-specified shifts. The interlock never fires on r15.
//  - Shift by immediate:
//    LSL #0 passes the value, carry=cpsr C
//    LSR #0 = LSR #32 (0, carry=bit31)
//    ASR #0 = ASR #32 (sign fill, carry=bit31)
//    ROR #0 = RRX ({C,v[31:1]}, carry=v[0])
//  - Shift by register uses Rs[7:0]:
//    amt 0: value unchanged, carry=C
//    LSL/LSR 32: 0, carry=bit0/bit31; >32: 0, carry=0
//    ASR >=32: sign fill, carry=bit31
//    ROR: amt[4:0]==0 gives value, carry=bit31
//  - Immediate operand: imm8 ROR 2*rot; carry=C if rot==0 else result[31].
//  - Interlock: !inbubble && exe_write_reg && exe_write_num (!=15) equals
//    any source actually used -> outstall=1, output registers load bubble
//    (outbubble=1) the same cycle. Released the cycle after execute moves on.
//  - Per-cycle priority (registered update):
//    1. Nrst
//    2. flush: outbubble<=1
//    3. stall: hold all outputs
//    4. interlock: outbubble<=1
//    5. otherwise load, with outbubble<=inbubble
//  - outstall = stall | interlock, combinational. Latency is 1 cycle when
//    there is no stall.
//  - flush together with stall: flush wins, bubble inserted.
// STRUCTURE
//  - Shared defines: DECODE_* class masks, CPSR_C/N/Z/V bit indices, SHIFT_LSL/
//    LSR/ASR/ROR codes, PC_AHEAD constants.
//  - Sub-module barrel_shifter: combinational; inputs (value, amt[7:0], type,
//    is_reg, cin); outputs (result, cout).
//  - Top level holds the operand mux, the interlock compare and the pipeline
//    register.
// TESTING
//  - MOV r0,r1,LSR #0 with r1=0x80000000 -> op1=0, carry=1, outbubble=0 one
//    cycle later.
//  - ADD r2,r15,#0xFF000000 (rot=4) at pc=0x100 -> op0=0x108, op1=0xFF000000,
//    carry=1.
//  - MOV r3,r4,ROR #0 (RRX) with C=1, r4=0x3 -> op1=0x80000001, carry=1.
//  - MOV r5,r6,LSL r7 with r7=0x21 -> op1=0, carry=0. With r7=0x100 -> op1=r6,
//    carry=C.
//  - exe writes r1; ADD r0,r1,r2 presented -> outstall=1 and a bubble issued;
//    next cycle with no exe write the insn issues with the new r1.
//  - Hold stall 3 cycles and assert flush in cycle 2 -> outbubble=1 after cycle
//    2, outputs frozen otherwise. Nrst during stall -> outbubble=1 next edge.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_pkg
// Description : Shared instruction-class, CPSR bit, shift code and PC offset
//               definitions for the operand fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_fetch_pkg;

    // Instruction classes that determine how operands are routed
    typedef enum logic [2:0] {
        DECODE_ALU    = 3'd0,
        DECODE_MULT   = 3'd1,
        DECODE_LDST   = 3'd2,
        DECODE_BRANCH = 3'd3,
        DECODE_OTHER  = 3'd4
    } decode_class_e;

    // CPSR flag bit positions
    localparam int c_CPSR_N = 31;
    localparam int c_CPSR_Z = 30;
    localparam int c_CPSR_C = 29;
    localparam int c_CPSR_V = 28;

    // Operand-2 shift type field encodings (insn[6:5])
    localparam logic [1:0] c_SHIFT_LSL = 2'b00;
    localparam logic [1:0] c_SHIFT_LSR = 2'b01;
    localparam logic [1:0] c_SHIFT_ASR = 2'b10;
    localparam logic [1:0] c_SHIFT_ROR = 2'b11;

    // Value of r15 as seen by an operand read
    localparam logic [31:0] c_PC_AHEAD    = 32'd8;
    localparam logic [31:0] c_PC_AHEAD_RS = 32'd12;

    // Classify from insn[27:22] and insn[7:4]; multiply must be tested
    // before the generic data-processing space it lives inside.
    function automatic decode_class_e decode_class(input logic [5:0] op_hi,
                                                   input logic [3:0] op_lo);
        decode_class_e cls;
        if (op_hi == 6'b000000 && op_lo == 4'b1001)
            cls = DECODE_MULT;
        else if (op_hi[5:4] == 2'b00)
            cls = DECODE_ALU;
        else if (op_hi[5:4] == 2'b01)
            cls = DECODE_LDST;
        else if (op_hi[5:3] == 3'b101)
            cls = DECODE_BRANCH;
        else
            cls = DECODE_OTHER;
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_barrel_shifter
// Description : ARM operand-2 barrel shifter, immediate or register amount,
//               including the #0 special encodings and RRX.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_barrel_shifter
    import operand_fetch_pkg::*;
(
    input  logic [31:0] i_value,
    input  logic [7:0]  i_amt,
    input  logic [1:0]  i_type,
    input  logic        i_is_reg,
    input  logic        i_cin,
    output logic [31:0] o_result,
    output logic        o_cout
);

    logic [4:0]  w_sh;
    logic [32:0] w_lsl;     // [31:0] result, [32] last bit shifted out
    logic [32:0] w_lsr;     // [32:1] result, [0] last bit shifted out
    logic [32:0] w_asr;
    logic [31:0] w_ror;
    logic [31:0] w_sign;
    logic        w_big;
    logic        w_is32;

    assign w_sh   = i_amt[4:0];
    assign w_lsl  = {1'b0, i_value} << w_sh;
    assign w_lsr  = {i_value, 1'b0} >> w_sh;
    assign w_asr  = $signed({i_value, 1'b0}) >>> w_sh;
    // 32 - sh modulo 32 is the two's complement of sh in five bits
    assign w_ror  = (i_value >> w_sh) | (i_value << (~w_sh + 5'd1));
    assign w_sign = {32{i_value[31]}};
    assign w_big  = |i_amt[7:5];
    assign w_is32 = (i_amt == 8'd32);

    // Select result/carry by shift type, amount range and amount source
    always_comb begin
        o_result = i_value;
        o_cout   = i_cin;
        if (!i_is_reg) begin
            if (w_sh == 5'd0) begin
                // #0 encodings other than LSL mean #32 or RRX
                case (i_type)
                    c_SHIFT_LSR: begin o_result = 32'd0;  o_cout = i_value[31]; end
                    c_SHIFT_ASR: begin o_result = w_sign; o_cout = i_value[31]; end
                    c_SHIFT_ROR: begin o_result = {i_cin, i_value[31:1]}; o_cout = i_value[0]; end
                    default:     begin o_result = i_value; o_cout = i_cin; end
                endcase
            end else begin
                case (i_type)
                    c_SHIFT_LSL: begin o_result = w_lsl[31:0];  o_cout = w_lsl[32]; end
                    c_SHIFT_LSR: begin o_result = w_lsr[32:1];  o_cout = w_lsr[0];  end
                    c_SHIFT_ASR: begin o_result = w_asr[32:1];  o_cout = w_asr[0];  end
                    default:     begin o_result = w_ror;        o_cout = w_ror[31]; end
                endcase
            end
        end else if (i_amt != 8'd0) begin
            case (i_type)
                c_SHIFT_LSL: begin
                    if (w_is32)     begin o_result = 32'd0; o_cout = i_value[0]; end
                    else if (w_big) begin o_result = 32'd0; o_cout = 1'b0; end
                    else            begin o_result = w_lsl[31:0]; o_cout = w_lsl[32]; end
                end
                c_SHIFT_LSR: begin
                    if (w_is32)     begin o_result = 32'd0; o_cout = i_value[31]; end
                    else if (w_big) begin o_result = 32'd0; o_cout = 1'b0; end
                    else            begin o_result = w_lsr[32:1]; o_cout = w_lsr[0]; end
                end
                c_SHIFT_ASR: begin
                    if (w_big) begin o_result = w_sign;      o_cout = i_value[31]; end
                    else       begin o_result = w_asr[32:1]; o_cout = w_asr[0]; end
                end
                default: begin
                    if (w_sh == 5'd0) begin o_result = i_value; o_cout = i_value[31]; end
                    else              begin o_result = w_ror;   o_cout = w_ror[31]; end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Register-read / operand-2 shift stage feeding execute, with a
//               read-after-write interlock against the instruction in execute.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter logic [31:0] PC_AHEAD    = c_PC_AHEAD,
    parameter logic [31:0] PC_AHEAD_RS = c_PC_AHEAD_RS
) (
    input  logic        clk,
    input  logic        Nrst,
    input  logic        stall,
    input  logic        flush,
    input  logic        inbubble,
    input  logic [31:0] inpc,
    input  logic [31:0] insn,
    input  logic [31:0] cpsr,
    output logic [3:0]  rf_rna,
    output logic [3:0]  rf_rnb,
    output logic [3:0]  rf_rnc,
    input  logic [31:0] rf_rda,
    input  logic [31:0] rf_rdb,
    input  logic [31:0] rf_rdc,
    input  logic        exe_write_reg,
    input  logic [3:0]  exe_write_num,
    output logic        outstall,
    output logic        outbubble,
    output logic [31:0] outpc,
    output logic [31:0] outinsn,
    output logic [31:0] outcpsr,
    output logic [31:0] op0,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic        carry
);

    decode_class_e w_class;
    logic        w_i;
    logic        w_regsh;
    logic        w_cin;
    logic [31:0] w_pc_val;
    logic [31:0] w_va, w_vb, w_vc;
    logic [7:0]  w_sh_amt;
    logic [31:0] w_sh_res;
    logic        w_sh_cout;
    logic [4:0]  w_rot_amt;
    logic [31:0] w_imm32;
    logic [31:0] w_imm_rot;
    logic        w_imm_c;
    logic        w_use_a, w_use_b, w_use_c;
    logic        w_interlock;
    logic [31:0] w_op0, w_op1, w_op2;
    logic        w_c;

    logic        r_bubble;
    logic        r_carry;
    logic [31:0] r_pc, r_insn, r_cpsr, r_op0, r_op1, r_op2;

    assign w_class  = decode_class(insn[27:22], insn[7:4]);
    assign w_i      = insn[25];
    assign w_regsh  = (w_class == DECODE_ALU) && !w_i && insn[4];
    assign w_cin    = cpsr[c_CPSR_C];
    assign w_pc_val = inpc + (w_regsh ? PC_AHEAD_RS : PC_AHEAD);

    // Register file port numbers; ALU with a register shift spends port C on Rs
    always_comb begin
        rf_rna = insn[19:16];
        rf_rnb = insn[3:0];
        rf_rnc = insn[15:12];
        if (w_class == DECODE_MULT) begin
            rf_rna = insn[3:0];
            rf_rnb = insn[11:8];
        end
        if (w_regsh)
            rf_rnc = insn[11:8];
    end

    assign w_va = (rf_rna == 4'd15) ? w_pc_val : rf_rda;
    assign w_vb = (rf_rnb == 4'd15) ? w_pc_val : rf_rdb;
    assign w_vc = (rf_rnc == 4'd15) ? w_pc_val : rf_rdc;

    assign w_sh_amt = w_regsh ? w_vc[7:0] : {3'b000, insn[11:7]};

    operand_fetch_barrel_shifter u_shifter (
        .i_value  (w_vb),
        .i_amt    (w_sh_amt),
        .i_type   (insn[6:5]),
        .i_is_reg (w_regsh),
        .i_cin    (w_cin),
        .o_result (w_sh_res),
        .o_cout   (w_sh_cout)
    );

    assign w_rot_amt = {insn[11:8], 1'b0};
    assign w_imm32   = {24'd0, insn[7:0]};
    assign w_imm_rot = (w_imm32 >> w_rot_amt) | (w_imm32 << (~w_rot_amt + 5'd1));
    assign w_imm_c   = (insn[11:8] == 4'd0) ? w_cin : w_imm_rot[31];

    // Route read data and shifter output into the three execute operands
    always_comb begin
        w_op0 = 32'd0;
        w_op1 = 32'd0;
        w_op2 = 32'd0;
        w_c   = w_cin;
        case (w_class)
            DECODE_ALU: begin
                w_op0 = w_va;
                w_op1 = w_i ? w_imm_rot : w_sh_res;
                w_c   = w_i ? w_imm_c   : w_sh_cout;
                // Holds Rd, except with a register shift where port C carried Rs
                w_op2 = w_vc;
            end
            DECODE_MULT: begin
                w_op0 = w_va;
                w_op1 = w_vb;
                w_op2 = w_vc;
            end
            DECODE_LDST: begin
                w_op0 = w_va;
                w_op1 = w_i ? w_sh_res : {20'd0, insn[11:0]};
                w_c   = w_i ? w_sh_cout : w_cin;
                w_op2 = w_vc;
            end
            DECODE_BRANCH: begin
                w_op0 = {{6{insn[23]}}, insn[23:0], 2'b00};
            end
            default: ;
        endcase
    end

    // Which read ports hold a register the instruction really consumes
    always_comb begin
        w_use_a = 1'b0;
        w_use_b = 1'b0;
        w_use_c = 1'b0;
        case (w_class)
            DECODE_ALU: begin
                // MOV/MVN ignore Rn
                w_use_a = (insn[24:21] != 4'b1101) && (insn[24:21] != 4'b1111);
                w_use_b = !w_i;
                w_use_c = w_regsh;
            end
            DECODE_MULT: begin
                w_use_a = 1'b1;
                w_use_b = 1'b1;
                w_use_c = insn[21];
            end
            DECODE_LDST: begin
                w_use_a = 1'b1;
                w_use_b = w_i;
                w_use_c = !insn[20];
            end
            default: ;
        endcase
    end

    assign w_interlock = !inbubble && exe_write_reg && (exe_write_num != 4'd15) &&
                         ((w_use_a && rf_rna == exe_write_num) ||
                          (w_use_b && rf_rnb == exe_write_num) ||
                          (w_use_c && rf_rnc == exe_write_num));

    assign outstall = stall | w_interlock;

    // Pipeline register: reset, flush, stall-hold, interlock bubble, load
    always_ff @(posedge clk) begin
        if (Nrst) begin
            r_bubble <= 1'b1;
            r_carry  <= 1'b0;
            r_pc     <= 32'd0;
            r_insn   <= 32'd0;
            r_cpsr   <= 32'd0;
            r_op0    <= 32'd0;
            r_op1    <= 32'd0;
            r_op2    <= 32'd0;
        end else if (flush) begin
            r_bubble <= 1'b1;
        end else if (!stall) begin
            if (w_interlock) begin
                r_bubble <= 1'b1;
            end else begin
                r_bubble <= inbubble;
                r_carry  <= w_c;
                r_pc     <= inpc;
                r_insn   <= insn;
                r_cpsr   <= cpsr;
                r_op0    <= w_op0;
                r_op1    <= w_op1;
                r_op2    <= w_op2;
            end
        end
    end

    assign outbubble = r_bubble;
    assign carry     = r_carry;
    assign outpc     = r_pc;
    assign outinsn   = r_insn;
    assign outcpsr   = r_cpsr;
    assign op0       = r_op0;
    assign op1       = r_op1;
    assign op2       = r_op2;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch: directed cases plus
//               randomized instructions against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        Nrst, stall, flush, inbubble;
    logic [31:0] inpc, insn, cpsr;
    logic [3:0]  rf_rna, rf_rnb, rf_rnc;
    logic [31:0] rf_rda, rf_rdb, rf_rdc;
    logic        exe_write_reg;
    logic [3:0]  exe_write_num;
    logic        outstall, outbubble, carry;
    logic [31:0] outpc, outinsn, outcpsr, op0, op1, op2;

    logic [31:0] regs [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] op0, op1, op2;
        logic        c;
        bit          k0, k1, k2, kc;
        logic [15:0] used;
    } exp_t;

    // Expected pipeline-register contents and which fields are defined
    logic        m_bub, m_c;
    logic [31:0] m_pc, m_insn, m_cpsr, m_op0, m_op1, m_op2;
    bit          v_bub = 0, v_pc = 0, v0 = 0, v1 = 0, v2 = 0, vc = 0;

    always #5 clk = ~clk;

    // Behavioural register file
    always_comb begin
        rf_rda = regs[rf_rna];
        rf_rdb = regs[rf_rnb];
        rf_rdc = regs[rf_rnc];
    end

    operand_fetch dut (
        .clk(clk), .Nrst(Nrst), .stall(stall), .flush(flush), .inbubble(inbubble),
        .inpc(inpc), .insn(insn), .cpsr(cpsr),
        .rf_rna(rf_rna), .rf_rnb(rf_rnb), .rf_rnc(rf_rnc),
        .rf_rda(rf_rda), .rf_rdb(rf_rdb), .rf_rdc(rf_rdc),
        .exe_write_reg(exe_write_reg), .exe_write_num(exe_write_num),
        .outstall(outstall), .outbubble(outbubble),
        .outpc(outpc), .outinsn(outinsn), .outcpsr(outcpsr),
        .op0(op0), .op1(op1), .op2(op2), .carry(carry)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [3:0] n, input int off);
        return (n == 4'd15) ? inpc + 32'(off) : regs[n];
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
        return (n == 0) ? v : ((v >> n) | (v << (32 - n)));
    endfunction

    // ARM shifter semantics written directly from the architecture rules
    function automatic void shift_model(input logic [31:0] v, input int amt, input int typ,
                                        input bit isreg, input logic c,
                                        output logic [31:0] r, output logic co);
        if (amt == 0 && isreg) begin
            r = v; co = c;
        end else if (amt == 0) begin
            case (typ)
                0: begin r = v; co = c; end
                1: begin r = 0; co = v[31]; end
                2: begin r = v[31] ? 32'hFFFF_FFFF : 32'h0; co = v[31]; end
                default: begin r = {c, v[31:1]}; co = v[0]; end
            endcase
        end else begin
            case (typ)
                0: if (amt < 32) begin r = v << amt; co = v[32 - amt]; end
                   else if (amt == 32) begin r = 0; co = v[0]; end
                   else begin r = 0; co = 0; end
                1: if (amt < 32) begin r = v >> amt; co = v[amt - 1]; end
                   else if (amt == 32) begin r = 0; co = v[31]; end
                   else begin r = 0; co = 0; end
                2: if (amt < 32) begin r = 32'($signed(v) >>> amt); co = v[amt - 1]; end
                   else begin r = v[31] ? 32'hFFFF_FFFF : 32'h0; co = v[31]; end
                default: begin
                    r  = ror32(v, amt % 32);
                    co = r[31];
                end
            endcase
        end
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic [31:0] r;
        logic        co;
        logic        cin = cpsr[29];
        logic [3:0]  rn = insn[19:16], rd_ = insn[15:12], rs = insn[11:8], rm = insn[3:0];
        bit          regsh;
        e = '{op0: 0, op1: 0, op2: 0, c: cin, k0: 0, k1: 0, k2: 0, kc: 0, used: 0};
        if (insn[27:22] == 6'd0 && insn[7:4] == 4'b1001) begin
            e.op0 = rd(rm, 8); e.op1 = rd(rs, 8); e.op2 = rd(rd_, 8);
            e.k0 = 1; e.k1 = 1; e.k2 = 1;
            if (rm != 15) e.used[rm] = 1;
            if (rs != 15) e.used[rs] = 1;
            if (insn[21] && rd_ != 15) e.used[rd_] = 1;
        end else if (insn[27:26] == 2'b00) begin
            regsh = !insn[25] && insn[4];
            e.op0 = rd(rn, regsh ? 12 : 8);
            if (insn[25]) begin
                r = ror32({24'd0, insn[7:0]}, 2 * int'(insn[11:8]));
                e.op1 = r;
                e.c = (insn[11:8] == 0) ? cin : r[31];
            end else begin
                shift_model(rd(rm, regsh ? 12 : 8),
                            regsh ? int'(rd(rs, 12) & 32'hFF) : int'(insn[11:7]),
                            int'(insn[6:5]), regsh, cin, r, co);
                e.op1 = r; e.c = co;
                if (rm != 15) e.used[rm] = 1;
                if (regsh && rs != 15) e.used[rs] = 1;
            end
            e.op2 = rd(rd_, 8);
            e.k0 = 1; e.k1 = 1; e.kc = 1; e.k2 = !regsh;
            if (insn[24:21] != 4'b1101 && insn[24:21] != 4'b1111 && rn != 15) e.used[rn] = 1;
        end else if (insn[27:26] == 2'b01) begin
            e.op0 = rd(rn, 8);
            if (insn[25]) begin
                shift_model(rd(rm, 8), int'(insn[11:7]), int'(insn[6:5]), 0, cin, r, co);
                e.op1 = r;
                if (rm != 15) e.used[rm] = 1;
            end else begin
                e.op1 = {20'd0, insn[11:0]};
            end
            e.op2 = rd(rd_, 8);
            e.k0 = 1; e.k1 = 1; e.k2 = 1;
            if (rn != 15) e.used[rn] = 1;
            if (!insn[20] && rd_ != 15) e.used[rd_] = 1;
        end else if (insn[27:25] == 3'b101) begin
            e.op0 = 32'($signed(insn[23:0])) * 4;
            e.k0 = 1;
        end else begin
            e.kc = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] b = $urandom();
        case ($urandom_range(0, 4))
            0: begin b[27:26] = 2'b00; if (!b[25] && b[4]) b[7] = 1'b0; end
            1: begin b[27:22] = 6'd0; b[7:4] = 4'b1001; end
            2: begin b[27:26] = 2'b01; if (b[25]) b[4] = 1'b0; end
            3: b[27:25] = 3'b101;
            default: b[27:24] = 4'b1111;
        endcase
        return b;
    endfunction

    // One clock: check outstall before the edge, then the registered outputs
    task automatic step();
        exp_t e;
        bit   ilk;
        #1;
        e   = model();
        ilk = !inbubble && exe_write_reg && exe_write_num != 4'd15 && e.used[exe_write_num];
        chk("outstall", {31'd0, outstall}, {31'd0, stall | ilk});
        @(posedge clk);
        if (Nrst) begin
            m_bub = 1; m_c = 0; m_pc = 0; m_insn = 0; m_cpsr = 0;
            m_op0 = 0; m_op1 = 0; m_op2 = 0;
            v_bub = 1; v_pc = 1; v0 = 1; v1 = 1; v2 = 1; vc = 1;
        end else if (flush || (!stall && ilk)) begin
            m_bub = 1; v_pc = 0; v0 = 0; v1 = 0; v2 = 0; vc = 0;
        end else if (!stall) begin
            m_bub = inbubble; m_pc = inpc; m_insn = insn; m_cpsr = cpsr; v_pc = 1;
            m_op0 = e.op0; m_op1 = e.op1; m_op2 = e.op2; m_c = e.c;
            v0 = e.k0 && !inbubble; v1 = e.k1 && !inbubble;
            v2 = e.k2 && !inbubble; vc = e.kc && !inbubble;
        end
        #1;
        if (v_bub) chk("outbubble", {31'd0, outbubble}, {31'd0, m_bub});
        if (v_pc) begin
            chk("outpc", outpc, m_pc);
            chk("outinsn", outinsn, m_insn);
            chk("outcpsr", outcpsr, m_cpsr);
        end
        if (v0) chk("op0", op0, m_op0);
        if (v1) chk("op1", op1, m_op1);
        if (v2) chk("op2", op2, m_op2);
        if (vc) chk("carry", {31'd0, carry}, {31'd0, m_c});
    endtask

    initial begin
        logic [31:0] r6val, newr1;
        for (int i = 0; i < 16; i++) regs[i] = $urandom();
        Nrst = 1; stall = 0; flush = 0; inbubble = 0;
        inpc = 32'h0; insn = 32'hE1A00000; cpsr = 32'h0;
        exe_write_reg = 0; exe_write_num = 4'd0;
        step();
        step();
        chk("reset_bubble", {31'd0, outbubble}, 32'd1);
        chk("reset_op1", op1, 32'd0);
        Nrst = 0;

        // MOV r0,r1,LSR #0
        regs[1] = 32'h8000_0000; insn = 32'hE1A00021; inpc = 32'h40;
        step();
        chk("lsr0_op1", op1, 32'd0);
        chk("lsr0_carry", {31'd0, carry}, 32'd1);
        chk("lsr0_bubble", {31'd0, outbubble}, 32'd0);

        // ADD r2,r15,#0xFF000000
        inpc = 32'h100; insn = 32'hE28F24FF;
        step();
        chk("imm_op0", op0, 32'h108);
        chk("imm_op1", op1, 32'hFF00_0000);
        chk("imm_carry", {31'd0, carry}, 32'd1);

        // MOV r3,r4,ROR #0 (RRX)
        cpsr = 32'h2000_0000; regs[4] = 32'h3; insn = 32'hE1A03064;
        step();
        chk("rrx_op1", op1, 32'h8000_0001);
        chk("rrx_carry", {31'd0, carry}, 32'd1);

        // MOV r5,r6,LSL r7
        r6val = $urandom() | 32'h1; regs[6] = r6val; regs[7] = 32'h21; insn = 32'hE1A05716;
        step();
        chk("lslr33_op1", op1, 32'd0);
        chk("lslr33_carry", {31'd0, carry}, 32'd0);
        regs[7] = 32'h100;
        step();
        chk("lslr256_op1", op1, r6val);
        chk("lslr256_carry", {31'd0, carry}, 32'd1);

        // Interlock on r1, then release
        insn = 32'hE0810002; exe_write_reg = 1; exe_write_num = 4'd1; inpc = 32'h200;
        step();
        chk("ilk_bubble", {31'd0, outbubble}, 32'd1);
        exe_write_reg = 0; newr1 = $urandom(); regs[1] = newr1;
        step();
        chk("ilk_release_op0", op0, newr1);
        chk("ilk_release_bubble", {31'd0, outbubble}, 32'd0);

        // Stall 3 cycles with flush in cycle 2, then reset during stall
        stall = 1; inpc = 32'h300; insn = 32'hE0811002;
        step();
        chk("stall_hold_pc", outpc, 32'h200);
        flush = 1;
        step();
        chk("stall_flush_bubble", {31'd0, outbubble}, 32'd1);
        flush = 0;
        step();
        stall = 0;
        step();
        stall = 1; Nrst = 1;
        step();
        chk("rst_in_stall_bubble", {31'd0, outbubble}, 32'd1);
        stall = 0; Nrst = 0;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            regs[$urandom_range(0, 15)] = $urandom();
            insn          = rand_insn();
            inpc          = $urandom() & 32'hFFFF_FFFC;
            cpsr          = $urandom();
            inbubble      = ($urandom_range(0, 7) == 0);
            stall         = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 15) == 0);
            Nrst          = ($urandom_range(0, 63) == 0);
            exe_write_reg = ($urandom_range(0, 2) == 0);
            exe_write_num = 4'($urandom_range(0, 15));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
